// File: rtl/issue_arbiter_rr_pkg.sv
// Shared definitions for the issue-stage round-robin arbiter.
package issue_arbiter_rr_pkg;

  // ALU class encoding; also the bit positions of the class request vector.
  typedef enum logic [1:0] {
    ClsSalu = 2'd0,
    ClsSimd = 2'd1,
    ClsSimf = 2'd2
  } alu_class_e;

  localparam int unsigned NumAluClasses = 3;

  // Default parameter values for the compute unit.
  localparam int unsigned DefNumWf     = 40;
  localparam int unsigned DefWfIdW     = 6;
  localparam int unsigned DefNumSimd   = 4;
  localparam int unsigned DefNumSimf   = 4;
  localparam int unsigned DefDualIssue = 1;

endpackage

// File: rtl/issue_arbiter_rr_rr_pick.sv
// Round-robin picker: returns the first set request strictly after ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan leaves the lowest request above the pointer and the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_idx = IDX_W'(j);
        if (IDX_W'(j) > ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    valid_o = |req_i;
    idx_o   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/issue_arbiter_rr.sv
// Dual-issue wavefront arbiter: one ALU-class grant and one LSU grant per cycle,
// round-robin over wavefronts, ALU classes and SIMD/SIMF units. Grants are registered.
module issue_arbiter_rr
  import issue_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_WF     = DefNumWf,
  parameter int unsigned WF_ID_W    = DefWfIdW,
  parameter int unsigned NUM_SIMD   = DefNumSimd,
  parameter int unsigned NUM_SIMF   = DefNumSimf,
  parameter int unsigned DUAL_ISSUE = DefDualIssue
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WF-1:0]   salu_ready_to_issue,
  input  logic [NUM_WF-1:0]   simd_ready_to_issue,
  input  logic [NUM_WF-1:0]   simf_ready_to_issue,
  input  logic [NUM_WF-1:0]   lsu_ready_to_issue,
  input  logic [NUM_SIMD-1:0] simd_alu_ready,
  input  logic [NUM_SIMF-1:0] simf_alu_ready,
  input  logic                salu_alu_ready,
  input  logic                lsu_ready,
  output logic [NUM_SIMD-1:0] simd_alu_select,
  output logic [NUM_SIMF-1:0] simf_alu_select,
  output logic                salu_alu_select,
  output logic                lsu_lsu_select,
  output logic [WF_ID_W-1:0]  alu_wfid,
  output logic [WF_ID_W-1:0]  lsu_wfid,
  output logic                alu_valid,
  output logic                lsu_valid
);

  localparam int unsigned SimdIdxW = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;
  localparam int unsigned SimfIdxW = (NUM_SIMF > 1) ? $clog2(NUM_SIMF) : 1;

  // State
  logic [NUM_WF-1:0]   mask_q, mask_d;
  logic [WF_ID_W-1:0]  salu_ptr_q, salu_ptr_d, simd_ptr_q, simd_ptr_d;
  logic [WF_ID_W-1:0]  simf_ptr_q, simf_ptr_d, lsu_ptr_q, lsu_ptr_d;
  logic [SimdIdxW-1:0] simd_unit_ptr_q, simd_unit_ptr_d;
  logic [SimfIdxW-1:0] simf_unit_ptr_q, simf_unit_ptr_d;
  logic [1:0]          cls_ptr_q, cls_ptr_d;
  logic                lsu_first_q, lsu_first_d;
  logic [NUM_SIMD-1:0] simd_sel_q, simd_sel_d;
  logic [NUM_SIMF-1:0] simf_sel_q, simf_sel_d;
  logic                salu_sel_q, salu_sel_d;
  logic                lsu_sel_q, lsu_sel_d;
  logic                alu_valid_q, alu_valid_d;
  logic [WF_ID_W-1:0]  alu_wfid_q, alu_wfid_d, lsu_wfid_q, lsu_wfid_d;

  // Hold-off: wavefronts granted last cycle are hidden from every class.
  logic [NUM_WF-1:0] salu_req, simd_req, simf_req, lsu_req;
  assign salu_req = salu_ready_to_issue & ~mask_q;
  assign simd_req = simd_ready_to_issue & ~mask_q;
  assign simf_req = simf_ready_to_issue & ~mask_q;
  assign lsu_req  = lsu_ready_to_issue & ~mask_q;

  logic               salu_wf_v, simd_wf_v, simf_wf_v, lsu_wf_v;
  logic [WF_ID_W-1:0] salu_wf, simd_wf, simf_wf, lsu_wf;

  rr_pick #(.N(NUM_WF), .IDX_W(WF_ID_W)) u_pick_salu (
    .req_i(salu_req), .ptr_i(salu_ptr_q), .valid_o(salu_wf_v), .idx_o(salu_wf)
  );
  rr_pick #(.N(NUM_WF), .IDX_W(WF_ID_W)) u_pick_simd (
    .req_i(simd_req), .ptr_i(simd_ptr_q), .valid_o(simd_wf_v), .idx_o(simd_wf)
  );
  rr_pick #(.N(NUM_WF), .IDX_W(WF_ID_W)) u_pick_simf (
    .req_i(simf_req), .ptr_i(simf_ptr_q), .valid_o(simf_wf_v), .idx_o(simf_wf)
  );
  rr_pick #(.N(NUM_WF), .IDX_W(WF_ID_W)) u_pick_lsu (
    .req_i(lsu_req), .ptr_i(lsu_ptr_q), .valid_o(lsu_wf_v), .idx_o(lsu_wf)
  );

  logic                simd_unit_v, simf_unit_v;
  logic [SimdIdxW-1:0] simd_unit;
  logic [SimfIdxW-1:0] simf_unit;

  rr_pick #(.N(NUM_SIMD), .IDX_W(SimdIdxW)) u_pick_simd_unit (
    .req_i(simd_alu_ready), .ptr_i(simd_unit_ptr_q), .valid_o(simd_unit_v), .idx_o(simd_unit)
  );
  rr_pick #(.N(NUM_SIMF), .IDX_W(SimfIdxW)) u_pick_simf_unit (
    .req_i(simf_alu_ready), .ptr_i(simf_unit_ptr_q), .valid_o(simf_unit_v), .idx_o(simf_unit)
  );

  // Class pointer names the first class to try; the picker searches after its argument,
  // so hand it the class before.
  logic [NumAluClasses-1:0] cls_req;
  logic [1:0]               cls_prev;
  logic                     alu_cand;
  logic [1:0]               cls_idx;

  assign cls_req  = {simf_wf_v & simf_unit_v, simd_wf_v & simd_unit_v,
                     salu_wf_v & salu_alu_ready};
  assign cls_prev = (cls_ptr_q == ClsSalu) ? ClsSimf : (cls_ptr_q - 2'd1);

  rr_pick #(.N(NumAluClasses), .IDX_W(2)) u_pick_class (
    .req_i(cls_req), .ptr_i(cls_prev), .valid_o(alu_cand), .idx_o(cls_idx)
  );

  logic               lsu_cand;
  logic [WF_ID_W-1:0] alu_wf_sel;
  assign lsu_cand = lsu_wf_v & lsu_ready;

  // Wavefront id of the winning ALU class.
  always_comb begin
    case (cls_idx)
      ClsSimd: alu_wf_sel = simd_wf;
      ClsSimf: alu_wf_sel = simf_wf;
      default: alu_wf_sel = salu_wf;
    endcase
  end

  logic alu_go, lsu_go;

  // Grant decision: dual issue with same-wf suppression, or single issue with a toggle.
  always_comb begin
    alu_go = 1'b0;
    lsu_go = 1'b0;
    if (DUAL_ISSUE != 0) begin
      alu_go = alu_cand;
      lsu_go = lsu_cand && !(alu_cand && (lsu_wf == alu_wf_sel));
    end else if (alu_cand && lsu_cand) begin
      alu_go = !lsu_first_q;
      lsu_go = lsu_first_q;
    end else begin
      alu_go = alu_cand;
      lsu_go = lsu_cand;
    end
  end

  // Next-state: pointers, hold-off mask and registered grants.
  always_comb begin
    mask_d          = '0;
    salu_ptr_d      = salu_ptr_q;
    simd_ptr_d      = simd_ptr_q;
    simf_ptr_d      = simf_ptr_q;
    lsu_ptr_d       = lsu_ptr_q;
    simd_unit_ptr_d = simd_unit_ptr_q;
    simf_unit_ptr_d = simf_unit_ptr_q;
    cls_ptr_d       = cls_ptr_q;
    lsu_first_d     = lsu_first_q ^ (alu_go | lsu_go);
    simd_sel_d      = '0;
    simf_sel_d      = '0;
    salu_sel_d      = 1'b0;
    lsu_sel_d       = lsu_go;
    alu_valid_d     = alu_go;
    alu_wfid_d      = alu_wfid_q;
    lsu_wfid_d      = lsu_wfid_q;
    if (alu_go) begin
      mask_d[alu_wf_sel] = 1'b1;
      alu_wfid_d         = alu_wf_sel;
      case (cls_idx)
        ClsSimd: begin
          simd_ptr_d            = simd_wf;
          simd_unit_ptr_d       = simd_unit;
          simd_sel_d[simd_unit] = 1'b1;
          cls_ptr_d             = ClsSimf;
        end
        ClsSimf: begin
          simf_ptr_d            = simf_wf;
          simf_unit_ptr_d       = simf_unit;
          simf_sel_d[simf_unit] = 1'b1;
          cls_ptr_d             = ClsSalu;
        end
        default: begin
          salu_ptr_d = salu_wf;
          salu_sel_d = 1'b1;
          cls_ptr_d  = ClsSimd;
        end
      endcase
    end
    if (lsu_go) begin
      mask_d[lsu_wf] = 1'b1;
      lsu_ptr_d      = lsu_wf;
      lsu_wfid_d     = lsu_wf;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q          <= '0;
      salu_ptr_q      <= WF_ID_W'(NUM_WF - 1);
      simd_ptr_q      <= WF_ID_W'(NUM_WF - 1);
      simf_ptr_q      <= WF_ID_W'(NUM_WF - 1);
      lsu_ptr_q       <= WF_ID_W'(NUM_WF - 1);
      simd_unit_ptr_q <= SimdIdxW'(NUM_SIMD - 1);
      simf_unit_ptr_q <= SimfIdxW'(NUM_SIMF - 1);
      cls_ptr_q       <= ClsSalu;
      lsu_first_q     <= 1'b0;
      simd_sel_q      <= '0;
      simf_sel_q      <= '0;
      salu_sel_q      <= 1'b0;
      lsu_sel_q       <= 1'b0;
      alu_valid_q     <= 1'b0;
      alu_wfid_q      <= '0;
      lsu_wfid_q      <= '0;
    end else begin
      mask_q          <= mask_d;
      salu_ptr_q      <= salu_ptr_d;
      simd_ptr_q      <= simd_ptr_d;
      simf_ptr_q      <= simf_ptr_d;
      lsu_ptr_q       <= lsu_ptr_d;
      simd_unit_ptr_q <= simd_unit_ptr_d;
      simf_unit_ptr_q <= simf_unit_ptr_d;
      cls_ptr_q       <= cls_ptr_d;
      lsu_first_q     <= lsu_first_d;
      simd_sel_q      <= simd_sel_d;
      simf_sel_q      <= simf_sel_d;
      salu_sel_q      <= salu_sel_d;
      lsu_sel_q       <= lsu_sel_d;
      alu_valid_q     <= alu_valid_d;
      alu_wfid_q      <= alu_wfid_d;
      lsu_wfid_q      <= lsu_wfid_d;
    end
  end

  assign simd_alu_select = simd_sel_q;
  assign simf_alu_select = simf_sel_q;
  assign salu_alu_select = salu_sel_q;
  assign lsu_lsu_select  = lsu_sel_q;
  assign alu_valid       = alu_valid_q;
  assign lsu_valid       = lsu_sel_q;
  assign alu_wfid        = alu_wfid_q;
  assign lsu_wfid        = lsu_wfid_q;

endmodule
